sdr_write_coalescer: RTL and testbench

//  Sits between the ROM download loader and the SDRAM controller write port.
//  - Accepts byte writes: a 16-bit word address plus a 2-bit byte enable.
//  - Merges the low and high bytes of the same word into one full-word write.
//  - Buffers the writes in a small FIFO.
//  - Issues them to SDRAM with a level request / pulse acknowledge handshake.
//  - Halves SDRAM write traffic during ROM download and absorbs controller stalls.
//

---
 rtl/sdr_write_coalescer.sv | 171 +++++++++++++++++
 tb/tb_sdr_write_coalescer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sdr_write_coalescer.sv
// sdr_write_coalescer: merges byte writes from the ROM download loader into
// full-word SDRAM writes, buffers them in a small FIFO and issues them with a
// level-request / pulse-acknowledge handshake.
//
// Ports:
//   sys_clk   - sole clock, rising edge
//   reset     - asynchronous active-high reset, clears all state
//   in_valid  - byte write present; accepted when in_valid && in_ready
//   in_ready  - registered FIFO-not-full indication
//   in_addr   - word address [24:1]
//   in_data   - write data, lane 0 = [7:0], lane 1 = [15:8]
//   in_be     - byte enable (01, 10 or 11)
//   flush     - 1-cycle pulse forcing the held partial word out
//   out_req   - SDRAM write request level
//   out_addr  - SDRAM word address
//   out_data  - SDRAM write data
//   out_be    - SDRAM byte enables
//   out_ack   - 1-cycle completion pulse from the controller
//   busy      - hold valid, FIFO non-empty or request outstanding
module sdr_write_coalescer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_addr,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_be,
  input  logic        flush,
  output logic        out_req,
  output logic [23:0] out_addr,
  output logic [15:0] out_data,
  output logic [1:0]  out_be,
  input  logic        out_ack,
  output logic        busy
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } wr_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t        state, state_n;
  wr_t           fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;

  logic          hold_valid, hold_valid_n;
  wr_t           hold, hold_n;
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic          flush_pending, flush_pending_n;

  logic          fifo_full, fifo_empty;
  logic          accept, mergeable, push, pop;

  assign out_req = (state == S_REQ);

  // Hold-register merge, push decision and idle/flush bookkeeping
  always_comb begin
    fifo_full       = (count == CW'(DEPTH));
    fifo_empty      = (count == CW'(0));
    accept          = in_valid & in_ready;
    mergeable       = hold_valid && (in_addr == hold.addr) && ((in_be & hold.be) == 2'b00);
    push            = hold_valid && !fifo_full &&
                      ((hold.be == 2'b11) || (idle_cnt == IW'(TIMEOUT - 1)) ||
                       flush_pending || (accept && !mergeable));
    hold_valid_n    = hold_valid;
    hold_n          = hold;
    idle_cnt_n      = idle_cnt;

    if (push) hold_valid_n = 1'b0;

    if (accept) begin
      // With hold occupied and no push, an accepted write is necessarily mergeable
      if (hold_valid && !push) begin
        if (in_be[0]) hold_n.data[7:0]  = in_data[7:0];
        if (in_be[1]) hold_n.data[15:8] = in_data[15:8];
        hold_n.be = hold.be | in_be;
      end else begin
        hold_valid_n = 1'b1;
        hold_n.addr  = in_addr;
        hold_n.be    = in_be;
        hold_n.data  = {(in_be[1] ? in_data[15:8] : 8'h00),
                        (in_be[0] ? in_data[7:0]  : 8'h00)};
      end
    end

    if (accept || push) begin
      idle_cnt_n = '0;
    end else if (hold_valid && (idle_cnt != IW'(TIMEOUT - 1))) begin
      idle_cnt_n = idle_cnt + IW'(1);
    end

    // A flush only matters while a word is held; it retires once hold drains
    flush_pending_n = (flush_pending | (flush & hold_valid)) & hold_valid_n;
  end

  // Output handshake next state; a pop happens only from idle
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (out_ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    count_n = count + CW'(push) - CW'(pop);
  end

  // State, hold, FIFO and output registers
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      hold_valid    <= 1'b0;
      hold          <= '0;
      idle_cnt      <= '0;
      flush_pending <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
      out_be        <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_mem[i] <= '0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      hold_valid    <= hold_valid_n;
      hold          <= hold_n;
      idle_cnt      <= idle_cnt_n;
      flush_pending <= flush_pending_n;
      in_ready      <= (count_n != CW'(DEPTH));
      busy          <= hold_valid_n | (count_n != CW'(0)) | (state_n == S_REQ);
      if (push) begin
        fifo_mem[wr_ptr] <= hold;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        out_addr <= fifo_mem[rd_ptr].addr;
        out_data <= fifo_mem[rd_ptr].data;
        out_be   <= fifo_mem[rd_ptr].be;
        rd_ptr   <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdr_write_coalescer.sv
// Scoreboard bench for sdr_write_coalescer: stimulus pushes expected SDRAM
// writes into a queue, a monitor compares each request as it is acknowledged.
module tb_sdr_write_coalescer;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_addr;
  logic [15:0] in_data;
  logic [1:0]  in_be;
  logic        flush;
  logic        out_req;
  logic [23:0] out_addr;
  logic [15:0] out_data;
  logic [1:0]  out_be;
  logic        out_ack;
  logic        busy;

  logic [41:0] exp_q [$];
  logic        ack_en;
  int          n_checks = 0;
  int          n_pass   = 0;

  sdr_write_coalescer #(.DEPTH(4), .TIMEOUT(64)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_be    (in_be),
    .flush    (flush),
    .out_req  (out_req),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_be   (out_be),
    .out_ack  (out_ack),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_wr(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
    exp_q.push_back({a, d, be});
  endtask

  task automatic send(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
    int t = 0;
    @(negedge sys_clk);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_be    = be;
    while (!in_ready && t < 2000) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 2000) check("send_timeout", 64'(t), 64'(0));
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge sys_clk);
    flush = 1'b1;
    @(posedge sys_clk);
    #1 flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((busy || out_req || exp_q.size() != 0) && t < 500) begin
      @(negedge sys_clk);
      t++;
    end
    check(name, 64'(t < 500), 64'(1));
  endtask

  // Monitor: compare each write when acknowledging it, one ack pulse per request
  always @(negedge sys_clk) begin
    if (reset) begin
      out_ack = 1'b0;
    end else if (out_ack) begin
      out_ack = 1'b0;
    end else if (out_req && ack_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got %0h expected none", {out_addr, out_data, out_be});
      end else begin
        check("write", 64'({out_addr, out_data, out_be}), 64'(exp_q.pop_front()));
      end
      out_ack = 1'b1;
    end
  end

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    in_be    = '0;
    flush    = 1'b0;
    out_ack  = 1'b0;
    ack_en   = 1'b1;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_out_req", 64'(out_req), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    @(negedge sys_clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // 1. Two halves of one word merge into a single full write
    expect_wr(24'h000010, 16'hBBAA, 2'b11);
    send(24'h000010, 16'h00AA, 2'b01);
    send(24'h000010, 16'hBB00, 2'b10);
    n = 0;
    while (!out_req && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check("merge_latency", 64'(n), 64'(3));
    drain("merge_drain");

    // 2. Lone byte is pushed by the idle timeout
    expect_wr(24'h000020, 16'h0055, 2'b01);
    send(24'h000020, 16'h0055, 2'b01);
    n = 0;
    while (!out_req && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("timeout_window", 64'(n >= 60 && n <= 70), 64'(1));
    drain("timeout_drain");

    // 3. Overlapping enables on one address stay separate and ordered
    expect_wr(24'h000030, 16'h0011, 2'b01);
    expect_wr(24'h000030, 16'h0022, 2'b01);
    send(24'h000030, 16'h0011, 2'b01);
    send(24'h000030, 16'h0022, 2'b01);
    pulse_flush();
    drain("overlap_drain");

    // 4. Backpressure: controller stalls while 8 words stream in
    ack_en = 1'b0;
    for (int i = 0; i < 8; i++) expect_wr(24'h000100 + 24'(i), {8'(8'h80 + i), 8'(i)}, 2'b11);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(24'h000100 + 24'(i), {8'h00, 8'(i)}, 2'b01);
          send(24'h000100 + 24'(i), {8'(8'h80 + i), 8'h00}, 2'b10);
        end
      end
      begin
        repeat (60) @(negedge sys_clk);
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_busy", 64'(busy), 64'(1));
        check("bp_out_req", 64'(out_req), 64'(1));
        ack_en = 1'b1;
      end
    join
    drain("bp_drain");

    // 5. Flush forces a partial word out quickly; busy drops after the ack
    expect_wr(24'h000040, 16'hCC00, 2'b10);
    send(24'h000040, 16'hCC00, 2'b10);
    pulse_flush();
    n = 0;
    while (!out_req && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check("flush_latency", 64'(n <= 3), 64'(1));
    n = 0;
    while (out_req && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check("flush_busy_fall", 64'(busy), 64'(0));
    drain("flush_drain");

    // 6. Reset mid-operation: one write outstanding, three queued, none survive
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(24'h000200 + 24'(i), 16'h0033, 2'b01);
      send(24'h000200 + 24'(i), 16'h4400, 2'b10);
    end
    repeat (5) @(negedge sys_clk);
    check("pre_rst_out_req", 64'(out_req), 64'(1));
    reset = 1'b1;
    #1;
    check("async_rst_out_req", 64'(out_req), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(negedge sys_clk);
    reset  = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rel_in_ready", 64'(in_ready), 64'(1));
    repeat (100) @(negedge sys_clk);
    check("no_stale_req", 64'(out_req), 64'(0));
    check("no_stale_busy", 64'(busy), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
